adc_phase_sign_sequencer: RTL

//  Upstream stage of the three-phase commutation FSMs. Drives the on-chip ADC

---
 rtl/adc_phase_sign_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adc_phase_sign_sequencer.sv
// Round-robins ADC conversions over phases A..C and turns each 12-bit current
// sample into a hysteretic sign bit for the downstream commutation FSMs.
module adc_phase_sign_sequencer #(
   parameter int NUM_CH    = 3,
   parameter int DATA_W    = 12,
   parameter int CH_BASE   = 1,
   parameter int THRESH_HI = 2100,
   parameter int THRESH_LO = 1996,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              pll_locked,
   input  logic              enable,
   output logic              cmd_valid,
   output logic [4:0]        cmd_channel,
   output logic              cmd_sop,
   output logic              cmd_eop,
   input  logic              cmd_ready,
   input  logic              rsp_valid,
   input  logic [4:0]        rsp_channel,
   input  logic [DATA_W-1:0] rsp_data,
   output logic [NUM_CH-1:0] curr_sign,
   output logic              sign_valid,
   output logic              frame_done,
   output logic              adc_fault
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      LOCK_WAIT,
      IDLE,
      ISSUE,
      WAIT_RSP
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    sign_pos;
   logic [TMR_W-1:0]    timer;
   logic [NUM_CH-1:0]   sampled;
   logic [NUM_CH-1:0]   sampled_upd;
   logic [NUM_CH-1:0]   sign_upd;
   logic [4:0]          exp_ch;
   logic                in_wait;
   logic                rsp_match;
   logic                rsp_wrong;
   logic                timed_out;
   logic                phase_done;
   logic                last_phase;

   // Phase A sits in the MSB of curr_sign, so idx maps onto a reversed bit position.
   assign exp_ch     = 5'(CH_BASE) + 5'(idx);
   assign sign_pos   = IDX_W'(NUM_CH - 1) - idx;
   assign last_phase = (idx == IDX_W'(NUM_CH - 1));

   // Lock loss silently drops whatever response is in flight.
   assign in_wait    = (state == WAIT_RSP) && pll_locked;
   assign rsp_match  = in_wait && rsp_valid && (rsp_channel == exp_ch);
   assign rsp_wrong  = in_wait && rsp_valid && (rsp_channel != exp_ch);
   assign timed_out  = in_wait && !rsp_match && (timer == TMR_W'(TIMEOUT));
   assign phase_done = rsp_match || timed_out;

   assign cmd_valid   = (state == ISSUE);
   assign cmd_channel = exp_ch;
   assign cmd_sop     = cmd_valid;
   assign cmd_eop     = cmd_valid;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of statement order; RST is synchronous here.
   always_ff @(posedge clk) begin
      if (RST) begin
         state <= LOCK_WAIT;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      if (!pll_locked) begin
         state_nxt = LOCK_WAIT;
      end else begin
         case (state)
            LOCK_WAIT: state_nxt = IDLE;
            IDLE:      if (enable) state_nxt = ISSUE;
            ISSUE:     if (cmd_ready) state_nxt = WAIT_RSP;
            WAIT_RSP:  if (phase_done) state_nxt = enable ? ISSUE : IDLE;
            default:   state_nxt = LOCK_WAIT;
         endcase
      end
   end

   // Hysteresis: inside the (THRESH_LO, THRESH_HI) band the previous sign holds.
   always_comb begin
      sign_upd    = curr_sign;
      sampled_upd = sampled;
      if (rsp_match) begin
         sampled_upd[sign_pos] = 1'b1;
         if (rsp_data >= DATA_W'(THRESH_HI)) begin
            sign_upd[sign_pos] = 1'b1;
         end else if (rsp_data <= DATA_W'(THRESH_LO)) begin
            sign_upd[sign_pos] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         idx        <= '0;
         timer      <= '0;
         curr_sign  <= '0;
         sampled    <= '0;
         sign_valid <= 1'b0;
         frame_done <= 1'b0;
         adc_fault  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         curr_sign  <= sign_upd;
         if (rsp_wrong || timed_out) begin
            adc_fault <= 1'b1;
         end
         timer <= (state == WAIT_RSP) ? timer + 1'b1 : '0;
         if (!pll_locked) begin
            idx        <= '0;
            sampled    <= '0;
            sign_valid <= 1'b0;
         end else begin
            sampled <= sampled_upd;
            if (phase_done) begin
               idx        <= last_phase ? '0 : idx + 1'b1;
               frame_done <= last_phase;
               // Only a real sample closing a fully sampled frame can validate signs.
               if (last_phase && rsp_match && (&sampled_upd)) begin
                  sign_valid <= 1'b1;
               end
            end
         end
      end
   end

endmodule
